// File: rtl/hcsr04_ranger.sv
`default_nettype none
// ============================================================================
// Module   : hcsr04_ranger
// Purpose  : HC-SR04 trigger generation, echo timing and us/cm conversion.
// Revision : 1.0
// ============================================================================
module hcsr04_ranger #(
    parameter int TRIG_CYCLES    = 640,
    parameter int CYCLES_PER_US  = 64,
    parameter int CYCLES_PER_CM  = 3712,
    parameter int TIMEOUT_CYCLES = 2432000,
    parameter int PERIOD_CYCLES  = 3840000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_single,
    input  logic        i_echo,
    output logic        o_trigger,
    output logic [15:0] o_echo_us,
    output logic [8:0]  o_distance_cm,
    output logic        o_valid,
    output logic        o_timeout,
    output logic        o_busy
);
    localparam int c_CNT_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_PER_W   = $clog2(PERIOD_CYCLES + 1);
    localparam int c_PUS_W   = $clog2(CYCLES_PER_US + 1);
    localparam int c_PCM_W   = $clog2(CYCLES_PER_CM + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = 1;
    localparam logic [c_CNT_W-1:0] c_TRIG_LAST = c_CNT_W'(TRIG_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_PER_W-1:0] c_PER_ONE   = 1;
    localparam logic [c_PER_W-1:0] c_PER_LAST  = c_PER_W'(PERIOD_CYCLES - 1);
    localparam logic [c_PUS_W-1:0] c_PUS_ONE   = 1;
    localparam logic [c_PUS_W-1:0] c_PUS_LAST  = c_PUS_W'(CYCLES_PER_US - 1);
    localparam logic [c_PCM_W-1:0] c_PCM_ONE   = 1;
    localparam logic [c_PCM_W-1:0] c_PCM_LAST  = c_PCM_W'(CYCLES_PER_CM - 1);
    localparam logic [15:0]        c_US_MAX    = 16'hFFFF;
    localparam logic [8:0]         c_CM_MAX    = 9'h1FF;

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_TRIG = 3'd1;
    localparam logic [2:0] c_S_WAIT = 3'd2;
    localparam logic [2:0] c_S_MEAS = 3'd3;
    localparam logic [2:0] c_S_HOLD = 3'd4;

    logic [2:0]         r_state_q, w_state_d;
    logic [2:0]         r_sync_q;
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic [c_PER_W-1:0] r_per_q, w_per_d;
    logic [c_PUS_W-1:0] r_pus_q, w_pus_d;
    logic [c_PCM_W-1:0] r_pcm_q, w_pcm_d;
    logic [15:0]        r_us_q, w_us_d;
    logic [8:0]         r_cm_q, w_cm_d;
    logic               r_trig_q, w_trig_d;
    logic [15:0]        r_echo_us_q, w_echo_us_d;
    logic [8:0]         r_dist_q, w_dist_d;
    logic               r_valid_q, w_valid_d;
    logic               r_tmo_q, w_tmo_d;
    logic               w_done_ok, w_done_tmo;
    logic               w_es, w_es_prev, w_rise, w_fall;

    // r_sync_q[1] is the synchronised echo; r_sync_q[2] is its previous value
    assign w_es      = r_sync_q[1];
    assign w_es_prev = r_sync_q[2];
    assign w_rise    = w_es & ~w_es_prev;
    assign w_fall    = ~w_es & w_es_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state_q   <= c_S_IDLE;
            r_sync_q    <= '0;
            r_cnt_q     <= '0;
            r_per_q     <= '0;
            r_pus_q     <= '0;
            r_pcm_q     <= '0;
            r_us_q      <= '0;
            r_cm_q      <= '0;
            r_trig_q    <= 1'b0;
            r_echo_us_q <= '0;
            r_dist_q    <= '0;
            r_valid_q   <= 1'b0;
            r_tmo_q     <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_sync_q    <= {r_sync_q[1:0], i_echo};
            r_cnt_q     <= w_cnt_d;
            r_per_q     <= w_per_d;
            r_pus_q     <= w_pus_d;
            r_pcm_q     <= w_pcm_d;
            r_us_q      <= w_us_d;
            r_cm_q      <= w_cm_d;
            r_trig_q    <= w_trig_d;
            r_echo_us_q <= w_echo_us_d;
            r_dist_q    <= w_dist_d;
            r_valid_q   <= w_valid_d;
            r_tmo_q     <= w_tmo_d;
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_per_d    = r_per_q + c_PER_ONE;
        w_pus_d    = r_pus_q;
        w_pcm_d    = r_pcm_q;
        w_us_d     = r_us_q;
        w_cm_d     = r_cm_q;
        w_done_ok  = 1'b0;
        w_done_tmo = 1'b0;
        case (r_state_q)
            c_S_IDLE: begin
                w_per_d = '0;
                if (i_enable || i_single) begin
                    w_state_d = c_S_TRIG;
                    w_cnt_d   = '0;
                end
            end
            c_S_TRIG: begin
                if (r_cnt_q == c_TRIG_LAST) begin
                    w_state_d = c_S_WAIT;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
            c_S_WAIT: begin
                if (w_rise) begin
                    w_state_d = c_S_MEAS;
                    w_cnt_d   = '0;
                    w_pus_d   = '0;
                    w_pcm_d   = '0;
                    w_us_d    = '0;
                    w_cm_d    = '0;
                end else if (r_cnt_q == c_TMO_LAST) begin
                    w_state_d  = c_S_HOLD;
                    w_done_tmo = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
            c_S_MEAS: begin
                // Counting the delayed echo includes the rise cycle and the fall cycle,
                // so N equals the synchronised high time exactly.
                if (w_es_prev) begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                    if (r_pus_q == c_PUS_LAST) begin
                        w_pus_d = '0;
                        if (r_us_q != c_US_MAX) w_us_d = r_us_q + 16'd1;
                    end else begin
                        w_pus_d = r_pus_q + c_PUS_ONE;
                    end
                    if (r_pcm_q == c_PCM_LAST) begin
                        w_pcm_d = '0;
                        if (r_cm_q != c_CM_MAX) w_cm_d = r_cm_q + 9'd1;
                    end else begin
                        w_pcm_d = r_pcm_q + c_PCM_ONE;
                    end
                end
                if (w_fall) begin
                    w_state_d = c_S_HOLD;
                    w_done_ok = 1'b1;
                end else if (r_cnt_q == c_TMO_LAST) begin
                    w_state_d  = c_S_HOLD;
                    w_done_tmo = 1'b1;
                end
            end
            c_S_HOLD: begin
                if (r_per_q == c_PER_LAST) begin
                    if (i_enable) begin
                        w_state_d = c_S_TRIG;
                        w_cnt_d   = '0;
                        w_per_d   = '0;
                    end else begin
                        w_state_d = c_S_IDLE;
                    end
                end
            end
            default: w_state_d = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_trig_d    = (w_state_d == c_S_TRIG);
        w_valid_d   = w_done_ok | w_done_tmo;
        w_echo_us_d = r_echo_us_q;
        w_dist_d    = r_dist_q;
        w_tmo_d     = r_tmo_q;
        if (w_done_tmo) begin
            w_echo_us_d = c_US_MAX;
            w_dist_d    = c_CM_MAX;
            w_tmo_d     = 1'b1;
        end else if (w_done_ok) begin
            w_echo_us_d = w_us_d;
            w_dist_d    = w_cm_d;
            w_tmo_d     = 1'b0;
        end
    end

    assign o_trigger     = r_trig_q;
    assign o_echo_us     = r_echo_us_q;
    assign o_distance_cm = r_dist_q;
    assign o_valid       = r_valid_q;
    assign o_timeout     = r_tmo_q;
    assign o_busy        = (r_state_q != c_S_IDLE);

endmodule
`default_nettype wire
